// File: rtl/jtag_ocimem_pkg.sv
// Shared definitions for the JTAG on-chip debug memory controller:
// jdo field positions, FSM state encoding and pending-command types.
package jtag_ocimem_pkg;

    localparam int JDO_W        = 38;
    localparam int JDO_LD       = 35;  // load MonAReg from the address field
    localparam int JDO_RD       = 34;  // start a read (ocimem_a only)
    localparam int JDO_CLR      = 25;  // clear monitor_error
    localparam int JDO_ADDR_LSB = 17;
    localparam int JDO_ADDR_W   = 8;
    localparam int JDO_DATA_LSB = 3;   // write data (ocimem_b)
    localparam int JDO_DATA_W   = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_J_RD  = 3'd1,
        S_J_CAP = 3'd2,
        S_J_WR  = 3'd3,
        S_A_RD  = 3'd4,
        S_A_RSP = 3'd5,
        S_A_WR  = 3'd6
    } state_t;

    // NOP: error-clear only; LD: address load without RAM access
    typedef enum logic [1:0] {
        CMD_NOP = 2'd0,
        CMD_LD  = 2'd1,
        CMD_RD  = 2'd2,
        CMD_WR  = 2'd3
    } cmd_t;

    typedef struct packed {
        logic                  vld;
        cmd_t                  cmd;
        logic                  ld;
        logic [JDO_ADDR_W-1:0] addr;
        logic [JDO_DATA_W-1:0] data;
    } pend_t;

    // Turn a take_* pulse plus its jdo word into a pending command.
    // take_a has priority over take_b; neither means the burst-read pulse.
    function automatic pend_t decode_cmd(input logic [JDO_W-1:0] jdo,
                                         input logic take_a,
                                         input logic take_b);
        pend_t p;
        p      = '0;
        p.vld  = 1'b1;
        p.addr = jdo[JDO_ADDR_LSB +: JDO_ADDR_W];
        p.data = jdo[JDO_DATA_LSB +: JDO_DATA_W];
        if (take_a) begin
            p.ld = jdo[JDO_LD];
            if (jdo[JDO_RD])      p.cmd = CMD_RD;
            else if (jdo[JDO_LD]) p.cmd = CMD_LD;
            else                  p.cmd = CMD_NOP;
        end else if (take_b) begin
            p.cmd = CMD_WR;
        end else begin
            p.cmd = CMD_RD;
        end
        return p;
    endfunction

endpackage

// File: rtl/jtag_ocimem_ram.sv
// Single-port debug RAM: byte-enabled write, registered one-cycle read.
// No reset: contents survive a controller reset.
module jtag_ocimem_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Byte-lane write and read-before-write registered output
    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_W/8; i++) begin
            if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/jtag_ocimem_ctrl.sv
// Arbitrates the debug RAM between JTAG monitor commands (via a 1-deep
// pending register) and a CPU-side Avalon slave. JTAG always wins.
module jtag_ocimem_ctrl
    import jtag_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [JDO_W-1:0]      jdo,
    input  logic                  take_action_ocimem_a,
    input  logic                  take_no_action_ocimem_a,
    input  logic                  take_action_ocimem_b,
    input  logic [ADDR_W-1:0]     address,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_W-1:0]     writedata,
    input  logic [DATA_W/8-1:0]   byteenable,
    output logic [DATA_W-1:0]     readdata,
    output logic                  waitrequest,
    output logic [DATA_W-1:0]     MonDReg,
    output logic                  monitor_ready,
    output logic                  monitor_error
);

    state_t              state, state_nxt;
    pend_t               pend, cmd_in;
    logic                take_any;
    logic [ADDR_W-1:0]   mon_a, mon_a_inc, j_addr;
    logic [DATA_W-1:0]   rd_hold, ram_q, ram_wdata;
    logic [ADDR_W-1:0]   ram_addr;
    logic                ram_we;
    logic [DATA_W/8-1:0] ram_be;

    assign take_any  = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign cmd_in    = decode_cmd(jdo, take_action_ocimem_a, take_action_ocimem_b);
    assign j_addr    = pend.ld ? pend.addr[ADDR_W-1:0] : mon_a;
    assign mon_a_inc = mon_a + ADDR_W'(1);
    assign readdata  = (state == S_A_RSP) ? ram_q : rd_hold;

    jtag_ocimem_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .be    (ram_be),
        .wdata (ram_wdata),
        .rdata (ram_q)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next state: pending or just-arriving JTAG work blocks new Avalon starts
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (pend.vld) begin
                    if (pend.cmd == CMD_RD)      state_nxt = S_J_RD;
                    else if (pend.cmd == CMD_WR) state_nxt = S_J_WR;
                end else if (!take_any) begin
                    if (read)       state_nxt = S_A_RD;
                    else if (write) state_nxt = S_A_WR;
                end
            end
            S_J_RD:  state_nxt = S_J_CAP;
            S_A_RD:  state_nxt = S_A_RSP;
            default: state_nxt = S_IDLE;
        endcase
    end

    // RAM port steering and Avalon handshake
    always_comb begin
        waitrequest = 1'b1;
        ram_addr    = address;
        ram_we      = 1'b0;
        ram_be      = '1;
        ram_wdata   = writedata;
        case (state)
            S_J_RD: ram_addr = j_addr;
            S_J_WR: begin
                ram_addr  = mon_a;
                ram_we    = 1'b1;
                ram_wdata = pend.data[DATA_W-1:0];
            end
            S_A_RSP: waitrequest = 1'b0;
            S_A_WR: begin
                waitrequest = 1'b0;
                ram_we      = 1'b1;
                ram_be      = byteenable;
            end
            default: ;
        endcase
    end

    // Pending command, monitor address/data/status and readdata hold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend          <= '0;
            mon_a         <= '0;
            MonDReg       <= '0;
            rd_hold       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (pend.vld && (pend.cmd == CMD_LD || pend.cmd == CMD_NOP)) begin
                    if (pend.cmd == CMD_LD) mon_a <= pend.addr[ADDR_W-1:0];
                    pend.vld <= 1'b0;
                end
                S_J_RD: begin
                    mon_a    <= j_addr;
                    pend.vld <= 1'b0;
                end
                S_J_CAP: begin
                    MonDReg       <= ram_q;
                    monitor_ready <= 1'b1;
                    mon_a         <= mon_a_inc;
                end
                S_J_WR: begin
                    mon_a    <= mon_a_inc;
                    pend.vld <= 1'b0;
                end
                S_A_RSP: rd_hold <= ram_q;
                default: ;
            endcase
            // A new pulse is only accepted into an empty pending slot
            if (take_any) begin
                if (pend.vld) begin
                    monitor_error <= 1'b1;
                end else begin
                    pend          <= cmd_in;
                    monitor_ready <= 1'b0;
                    if (take_action_ocimem_a && jdo[JDO_CLR]) monitor_error <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_jtag_ocimem_ctrl.sv
// Randomized bench for jtag_ocimem_ctrl with a behavioural memory/monitor model.
module tb_jtag_ocimem_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_a, take_na, take_b;
    logic [7:0]  address;
    logic        read, write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata, MonDReg;
    logic        waitrequest, monitor_ready, monitor_error;

    // Reference model state
    logic [31:0] m_mem [256];
    logic [7:0]  m_a;
    logic [31:0] m_d, m_last_rd;
    logic        m_rdy, m_err;

    int n_chk  = 0;
    int n_fail = 0;

    jtag_ocimem_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_no_action_ocimem_a (take_na),
        .take_action_ocimem_b    (take_b),
        .address                 (address),
        .read                    (read),
        .write                   (write),
        .writedata               (writedata),
        .byteenable              (byteenable),
        .readdata                (readdata),
        .waitrequest             (waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] jdo_a(input logic ld, input logic rd, input logic clr,
                                          input logic [7:0] a);
        logic [37:0] j;
        j = '0;
        j[35] = ld;
        j[34] = rd;
        j[25] = clr;
        j[24:17] = a;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic av_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        bit done = 0;
        address = a; writedata = d; byteenable = be; write = 1'b1;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (!waitrequest) done = 1;
            tick();
        end
        write = 1'b0;
        if (!done) chk("av_wr_timeout", 32'd1, 32'd0);
        for (int b = 0; b < 4; b++) if (be[b]) m_mem[a][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic av_read(input logic [7:0] a, input string tag);
        bit done = 0;
        logic [31:0] d = '0;
        address = a; read = 1'b1;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (!waitrequest) begin
                done = 1;
                d = readdata;
            end
            tick();
        end
        read = 1'b0;
        if (!done) chk("av_rd_timeout", 32'd1, 32'd0);
        else       chk(tag, d, m_mem[a]);
        m_last_rd = m_mem[a];
    endtask

    // kind: 0 = ocimem_a, 1 = burst read, 2 = ocimem_b; issued from quiescent state
    task automatic jtag_cmd(input int kind, input logic [37:0] j);
        bit is_rd;
        jdo = j;
        take_a = (kind == 0); take_na = (kind == 1); take_b = (kind == 2);
        tick();
        take_a = 0; take_na = 0; take_b = 0;
        is_rd = (kind == 1) || (kind == 0 && j[34]);
        m_rdy = 1'b0;
        if (kind == 0) begin
            if (j[25]) m_err = 1'b0;
            if (j[35]) m_a = j[24:17];
        end
        if (is_rd) begin
            m_d = m_mem[m_a];
            m_a = m_a + 8'd1;
        end else if (kind == 2) begin
            m_mem[m_a] = j[34:3];
            m_a = m_a + 8'd1;
        end
        tick();
        tick();
        if (is_rd) chk("ready_early", {31'd0, monitor_ready}, 32'd0);
        tick();
        if (is_rd) m_rdy = 1'b1;
        @(negedge clk);
        chk("mon_ready", {31'd0, monitor_ready}, {31'd0, m_rdy});
        chk("mon_data", MonDReg, m_d);
        chk("mon_error", {31'd0, monitor_error}, {31'd0, m_err});
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdata"}, readdata, 32'd0);
        chk({tag, "_wait"}, {31'd0, waitrequest}, 32'd1);
        chk({tag, "_mond"}, MonDReg, 32'd0);
        chk({tag, "_rdy"}, {31'd0, monitor_ready}, 32'd0);
        chk({tag, "_err"}, {31'd0, monitor_error}, 32'd0);
    endtask

    initial begin
        logic [7:0]  ra;
        logic [31:0] rd;
        bit          done;
        reset_n = 1'b0; jdo = '0; take_a = 0; take_na = 0; take_b = 0;
        address = '0; read = 0; write = 0; writedata = '0; byteenable = '0;
        m_a = '0; m_d = '0; m_rdy = 0; m_err = 0; m_last_rd = '0;
        tick(); tick();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick();

        // Fill the whole RAM so every model entry is defined
        for (int i = 0; i < 256; i++) av_write(8'(i), $urandom, 4'hF);

        // Addressed JTAG read then burst continues at the incremented address
        av_write(8'h10, 32'hDEADBEEF, 4'hF);
        jtag_cmd(0, jdo_a(1, 1, 0, 8'h10));
        chk("deadbeef", MonDReg, 32'hDEADBEEF);
        jtag_cmd(1, '0);

        // Address load then two writes wrapping past the top
        jtag_cmd(0, jdo_a(1, 0, 0, 8'hFF));
        jtag_cmd(2, jdo_b(32'h1));
        jtag_cmd(2, jdo_b(32'h2));
        av_read(8'hFF, "wrap_ff");
        av_read(8'h00, "wrap_00");

        // Avalon read and JTAG read in the same cycle: JTAG completes first
        address = 8'h33; read = 1'b1;
        jdo = jdo_a(1, 1, 0, 8'h44); take_a = 1'b1;
        tick();
        take_a = 1'b0;
        m_d = m_mem[8'h44]; m_a = 8'h45; m_rdy = 1'b0;
        done = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (!waitrequest) begin
                done = 1;
                chk("arb_jtag_first", {31'd0, monitor_ready}, 32'd1);
                chk("arb_mond", MonDReg, m_mem[8'h44]);
                chk("arb_rdata", readdata, m_mem[8'h33]);
            end
            tick();
        end
        read = 1'b0;
        m_rdy = 1'b1;
        m_last_rd = m_mem[8'h33];
        if (!done) chk("arb_timeout", 32'd1, 32'd0);

        // Overlapping pulse is dropped and flags error; first command executes
        jdo = jdo_b(32'hCAFE0001); take_b = 1'b1;
        tick();
        take_b = 1'b0; jdo = '0; take_na = 1'b1;
        tick();
        take_na = 1'b0;
        m_mem[m_a] = 32'hCAFE0001; m_a = m_a + 8'd1; m_rdy = 1'b0; m_err = 1'b1;
        tick(); tick();
        chk("drop_err", {31'd0, monitor_error}, 32'd1);
        av_read(m_a - 8'd1, "drop_first_wr");
        jtag_cmd(1, '0);
        jtag_cmd(0, jdo_a(0, 0, 1, 8'h00));
        chk("err_cleared", {31'd0, monitor_error}, 32'd0);

        // Randomized mix of Avalon and JTAG traffic
        for (int n = 0; n < 250; n++) begin
            ra = 8'($urandom);
            rd = $urandom;
            case ($urandom_range(0, 4))
                0: av_write(ra, rd, 4'($urandom));
                1: av_read(ra, "rnd_av_rd");
                2: jtag_cmd(0, jdo_a(1'($urandom), 1'($urandom), 1'($urandom), ra));
                3: jtag_cmd(1, '0);
                default: jtag_cmd(2, jdo_b(rd));
            endcase
            @(negedge clk);
            chk("rdata_hold", readdata, m_last_rd);
            @(posedge clk);
            #1;
        end

        // Byte-enabled write over zero
        av_write(8'h00, 32'h0, 4'hF);
        av_write(8'h00, 32'hAABBCCDD, 4'b0101);
        av_read(8'h00, "byte_en");
        chk("byte_en_val", m_mem[8'h00], 32'h00BB00DD);

        // Reset in the middle of an Avalon read
        address = 8'h21; read = 1'b1;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid_rd");
        read = 1'b0;
        m_a = '0; m_d = '0; m_rdy = 0; m_err = 0; m_last_rd = '0;
        tick();
        reset_n = 1'b1;
        tick();

        // Reset in the middle of an Avalon write must not write the RAM
        address = 8'h22; writedata = ~m_mem[8'h22]; byteenable = 4'hF; write = 1'b1;
        tick();
        reset_n = 1'b0;
        #1;
        write = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        av_read(8'h22, "rst_no_wr");
        av_read(8'h21, "rst_ram_kept");
        jtag_cmd(1, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/jtag_ocimem_ctrl.md
JTAG_OCIMEM_CTRL -- requirements
Module: jtag_ocimem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, 8, word-address width of debug RAM (2**ADDR_W words).
REQ-002 SHALL have parameter DATA_W, 32, RAM/monitor data width.
REQ-003 SHALL have clk  in  1  single system clock; all logic on rising edge.
REQ-004 SHALL have reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have jdo  in  38  JTAG data word, valid in the take_* pulse cycle.
REQ-006 SHALL have take_action_ocimem_a  in  1  one-cycle pulse: address/read/error-clear command.
REQ-007 SHALL have take_no_action_ocimem_a  in  1  one-cycle pulse: burst read at current address.
REQ-008 SHALL have take_action_ocimem_b  in  1  one-cycle pulse: write jdo[34:3] at current address.
REQ-009 SHALL have address  in  ADDR_W, read  in  1, write  in  1, writedata  in  32, byteenable  in  4: CPU-side Avalon slave.
REQ-010 SHALL have readdata  out  32, waitrequest  out  1: Avalon response.
REQ-011 SHALL have MonDReg  out  32, monitor_ready  out  1, monitor_error  out  1: JTAG-side readback and status.

Function
REQ-012 jdo fields SHALL be: [35] load-address, [34] start-read (ocimem_a only), [25] clear-error, [24:17] word address; [34:3] write data (ocimem_b).
REQ-013 Any take_* pulse SHALL be captured into a 1-deep pending-command register (type, address field, data) the same edge; monitor_ready SHALL clear on that edge.
REQ-014 A take_* pulse while pending is valid SHALL be dropped and set monitor_error (sticky); pending contents unchanged.
REQ-015 ocimem_a with jdo[25]=1 SHALL clear monitor_error; if jdo[35]=0 and jdo[34]=0 no RAM access occurs.
REQ-016 FSM states SHALL be IDLE, J_RD, J_CAP, J_WR, A_RD, A_RSP, A_WR.
REQ-017 IDLE: pending valid -> J_RD (read cmd) or J_WR (write cmd); else read=1 -> A_RD; else write=1 -> A_WR; JTAG SHALL win when both present same cycle.
REQ-018 J_RD: MonAReg updated if load-address set; RAM addressed with resulting MonAReg; pending cleared; -> J_CAP.
REQ-019 J_CAP: MonDReg <= RAM data, monitor_ready <= 1, MonAReg <= MonAReg+1 (wraps 2**ADDR_W-1 -> 0); -> IDLE. Pulse-to-MonDReg-valid latency: 3 cycles.
REQ-020 J_WR: RAM[MonAReg] <= pending data (all bytes), MonAReg+1 with wrap, pending cleared; -> IDLE.
REQ-021 A_RD: RAM addressed with address; -> A_RSP. A_RSP: readdata valid, waitrequest=0 one cycle; -> IDLE.
REQ-022 A_WR: byte-enabled write of writedata to RAM[address], waitrequest=0 one cycle; -> IDLE.
REQ-023 waitrequest SHALL be 1 in every state other than A_RSP/A_WR; Avalon master holds address/read/write/writedata until waitrequest=0.
REQ-024 A take_* pulse arriving during an Avalon transaction SHALL wait in pending and execute at the next IDLE, before any further Avalon request.
REQ-025 readdata SHALL hold its last value outside A_RSP.

Reset
REQ-026 reset_n low SHALL immediately force: FSM IDLE, pending invalid, MonAReg=0, MonDReg=0, readdata=0, monitor_ready=0, monitor_error=0, waitrequest=1.
REQ-027 RAM contents SHALL be unaffected by reset; reset mid-transaction SHALL abort it with no further RAM write.

Structure
REQ-028 jdo bit positions, FSM state encoding and command-type codes SHALL live in shared package jtag_ocimem_pkg.
REQ-029 RAM SHALL be sub-module jtag_ocimem_ram: single-port, byte-enable write, registered 1-cycle read.

Verification
REQ-030 ocimem_a jdo[35]=1,[34]=1,addr=0x10 with RAM[0x10]=0xDEADBEEF -> MonDReg=0xDEADBEEF, monitor_ready=1 3 cycles later, MonAReg=0x11.
REQ-031 ocimem_b ×2 with data 0x1, 0x2 after address load 0xFF -> RAM[0xFF]=1, RAM[0x00]=2 (wrap); Avalon reads return same.
REQ-032 Avalon read and ocimem_a pulse same cycle -> JTAG read completes first; Avalon waitrequest low only after, readdata correct.
REQ-033 Second take_* pulse while pending valid -> monitor_error=1, first command executes; ocimem_a jdo[25]=1 -> monitor_error=0.
REQ-034 Avalon write 0xAABBCCDD byteenable=4'b0101 over 0x0 -> RAM=0x00BB00DD; reset_n pulsed mid A_RD -> all outputs at REQ-026 values, RAM intact.
